// File: rtl/zrl_src_arbiter_if.sv
// Bundles the per-source request streams and the encoder input handshake of zrl_src_arbiter.
// master is the arbiter side; slave is the sources-plus-encoder side.
interface zrl_src_arbiter_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned DW    = 64
);
  logic [N_SRC*DW-1:0] req_data_i;
  logic [N_SRC-1:0]    req_valid_i;
  logic [N_SRC-1:0]    req_sop_i;
  logic [N_SRC-1:0]    req_eop_i;
  logic [N_SRC-1:0]    req_ready_o;
  logic [DW-1:0]       enc_data_o;
  logic                enc_valid_o;
  logic                enc_sop_o;
  logic                enc_eop_o;
  logic                enc_ready_i;

  modport master (
    input  req_data_i, req_valid_i, req_sop_i, req_eop_i, enc_ready_i,
    output req_ready_o, enc_data_o, enc_valid_o, enc_sop_o, enc_eop_o
  );

  modport slave (
    output req_data_i, req_valid_i, req_sop_i, req_eop_i, enc_ready_i,
    input  req_ready_o, enc_data_o, enc_valid_o, enc_sop_o, enc_eop_o
  );
endinterface

// File: rtl/zrl_src_arbiter.sv
// Packet-granular round-robin arbiter sharing one ZRL encoder among N_SRC streams, with a
// source-ID tag aligned to the encoder's one-cycle registered output.
module zrl_src_arbiter #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SRC_W = 2,
  parameter int unsigned DW    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  zrl_src_arbiter_if.master  bus,
  output logic [N_SRC-1:0]   grant_o,
  output logic               busy_o,
  output logic [SRC_W-1:0]   src_id_o,
  output logic               src_valid_o,
  output logic               err_sop_o
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e           r_state, w_state_d;
  logic [SRC_W-1:0] r_owner, w_owner_d;
  logic [SRC_W-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [SRC_W-1:0] r_src_id, w_src_id_d;
  logic             r_src_valid, w_src_valid_d;
  logic             r_err_sop, w_err_sop_d;
  // Set once the first beat of the locked packet has been accepted.
  logic             r_mid, w_mid_d;

  logic [N_SRC-1:0] w_elig;
  logic             w_found;
  logic [SRC_W-1:0] w_winner;
  logic             w_own_valid, w_own_sop, w_own_eop;
  logic [DW-1:0]    w_own_data;
  logic             w_lock;
  logic             w_xfer;

  assign w_elig = bus.req_valid_i & bus.req_sop_i;
  assign w_lock = (r_state == StLock);

  // Rotating search from rr_ptr+1; first eligible source wins.
  always_comb begin
    int unsigned w_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned off = 1; off <= N_SRC; off++) begin
      w_idx = (32'(r_rr_ptr) + off) % N_SRC;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (!w_found && (k == w_idx) && w_elig[k]) begin
          w_found  = 1'b1;
          w_winner = SRC_W'(k);
        end
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_sop   = 1'b0;
    w_own_eop   = 1'b0;
    w_own_data  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (r_owner == SRC_W'(k)) begin
        w_own_valid = bus.req_valid_i[k];
        w_own_sop   = bus.req_sop_i[k];
        w_own_eop   = bus.req_eop_i[k];
        w_own_data  = bus.req_data_i[k*DW +: DW];
      end
    end
  end

  assign w_xfer = w_lock & w_own_valid & bus.enc_ready_i;

  always_comb begin
    bus.enc_data_o  = '0;
    bus.enc_valid_o = 1'b0;
    bus.enc_sop_o   = 1'b0;
    bus.enc_eop_o   = 1'b0;
    bus.req_ready_o = '0;
    grant_o         = '0;
    if (w_lock) begin
      bus.enc_data_o  = w_own_data;
      bus.enc_valid_o = w_own_valid;
      bus.enc_sop_o   = w_own_sop;
      bus.enc_eop_o   = w_own_eop;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (r_owner == SRC_W'(k)) begin
          bus.req_ready_o[k] = bus.enc_ready_i;
          grant_o[k]         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_rr_ptr_d    = r_rr_ptr;
    w_mid_d       = r_mid;
    w_src_id_d    = r_src_id;
    w_src_valid_d = 1'b0;
    w_err_sop_d   = 1'b0;
    case (r_state)
      StIdle: begin
        w_mid_d = 1'b0;
        if (w_found) begin
          w_owner_d = w_winner;
          w_state_d = StLock;
        end
      end
      StLock: begin
        if (w_xfer) begin
          w_src_id_d    = r_owner;
          w_src_valid_d = 1'b1;
          // A sop after the first beat is forwarded as-is but flagged.
          w_err_sop_d   = w_own_sop & r_mid;
          if (w_own_eop) begin
            w_rr_ptr_d = r_owner;
            w_state_d  = StIdle;
            w_mid_d    = 1'b0;
          end else begin
            w_mid_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_owner     <= '0;
      r_rr_ptr    <= SRC_W'(N_SRC - 1);
      r_src_id    <= '0;
      r_src_valid <= 1'b0;
      r_err_sop   <= 1'b0;
      r_mid       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_src_id    <= w_src_id_d;
      r_src_valid <= w_src_valid_d;
      r_err_sop   <= w_err_sop_d;
      r_mid       <= w_mid_d;
    end
  end

  assign busy_o      = w_lock;
  assign src_id_o    = r_src_id;
  assign src_valid_o = r_src_valid;
  assign err_sop_o   = r_err_sop;

endmodule

// File: tb/tb_zrl_src_arbiter.sv
// Directed bench for zrl_src_arbiter: reset, round-robin order, lock, backpressure,
// single-beat packets, protocol errors and asynchronous reset mid-packet.
module tb_zrl_src_arbiter;
  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] grant_o;
  logic          busy_o;
  logic [SW-1:0] src_id_o;
  logic          src_valid_o;
  logic          err_sop_o;

  zrl_src_arbiter_if #(.N_SRC(NS), .DW(DW)) bus ();

  zrl_src_arbiter #(.N_SRC(NS), .SRC_W(SW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .src_id_o    (src_id_o),
    .src_valid_o (src_valid_o),
    .err_sop_o   (err_sop_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-source packet generator state.
  int          pk   [NS];
  int          nb   [NS];
  int          bt   [NS];
  int          sopx [NS];
  logic        nosop[NS];
  logic [63:0] base [NS];
  logic        rdy_cfg;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_srcs();
    for (int k = 0; k < NS; k++) begin
      pk[k] = 0; nb[k] = 1; bt[k] = 0; sopx[k] = -1; nosop[k] = 1'b0; base[k] = '0;
    end
    rdy_cfg = 1'b1;
  endtask

  task automatic drive_srcs();
    for (int k = 0; k < NS; k++) begin
      bus.req_valid_i[k]         = (pk[k] > 0);
      bus.req_sop_i[k]           = ((bt[k] == 0) && !nosop[k]) || (bt[k] == sopx[k]);
      bus.req_eop_i[k]           = (bt[k] == nb[k] - 1);
      bus.req_data_i[k*DW +: DW] = base[k] + 64'(bt[k]) * 64'h100;
    end
    bus.enc_ready_i = rdy_cfg;
  endtask

  // Called at a negedge; advances one clock and returns at the next negedge.
  task automatic step();
    logic [NS-1:0] acc;
    acc = bus.req_valid_i & bus.req_ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      if (acc[k]) begin
        if (bt[k] == nb[k] - 1) begin
          bt[k] = 0;
          pk[k]--;
        end else begin
          bt[k]++;
        end
      end
    end
    drive_srcs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, ph, own;
    logic [63:0] exp_d;

    // Reset with every source offering sop, then five 2-beat packets in rotation.
    clr_srcs();
    for (int k = 0; k < NS; k++) begin
      pk[k] = 2; nb[k] = 2; base[k] = 64'hA0 + 64'(k);
    end
    rst_n = 1'b0;
    drive_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ready", bus.req_ready_o, 0);
    check("rst_enc_valid", bus.enc_valid_o, 0);
    check("rst_enc_data", bus.enc_data_o, 0);
    check("rst_src_valid", src_valid_o, 0);
    check("rst_err", err_sop_o, 0);
    rst_n = 1'b1;
    check("idle0_grant", grant_o, 0);
    for (int c = 1; c <= 15; c++) begin
      step();
      p   = (c - 1) / 3;
      ph  = (c - 1) % 3;
      own = p % 4;
      exp_d = (ph == 0) ? 64'hA0 + 64'(own) : (ph == 1) ? 64'h1A0 + 64'(own) : 64'h0;
      if (c == 1) check("rr_first_grant", grant_o, 4'b0001);
      check($sformatf("rr_valid_c%0d", c), bus.enc_valid_o, (ph < 2) ? 1 : 0);
      check($sformatf("rr_data_c%0d", c), bus.enc_data_o, exp_d);
      check($sformatf("rr_srcv_c%0d", c), src_valid_o, (ph != 0) ? 1 : 0);
      if (ph != 0) check($sformatf("rr_srcid_c%0d", c), src_id_o, 64'(own));
    end

    // Lock under contention: source 2 holds a 4-beat packet while 0 and 3 request.
    clr_srcs();
    pk[2] = 1; nb[2] = 4; base[2] = 64'hC2;
    do_reset();
    step();
    check("lk_grant_c1", grant_o, 4'b0100);
    check("lk_data_c1", bus.enc_data_o, 64'hC2);
    pk[0] = 1; nb[0] = 2; base[0] = 64'hB0;
    pk[3] = 1; nb[3] = 1; base[3] = 64'hB3;
    step();
    check("lk_ready_c2", bus.req_ready_o, 4'b0100);
    check("lk_data_c2", bus.enc_data_o, 64'h1C2);
    step();
    check("lk_ready_c3", bus.req_ready_o, 4'b0100);
    step();
    check("lk_eop_c4", bus.enc_eop_o, 1);
    check("lk_data_c4", bus.enc_data_o, 64'h3C2);
    step();
    check("lk_idle_busy", busy_o, 0);
    check("lk_idle_grant", grant_o, 0);
    step();
    check("lk_next_src3", grant_o, 4'b1000);
    check("lk_data_c6", bus.enc_data_o, 64'hB3);
    step();
    check("lk_srcid_c7", src_id_o, 3);
    step();
    check("lk_then_src0", grant_o, 4'b0001);

    // Backpressure for five cycles inside a 3-beat packet from source 1.
    clr_srcs();
    pk[1] = 1; nb[1] = 3; base[1] = 64'hD1;
    do_reset();
    step();
    check("bp_grant", grant_o, 4'b0010);
    check("bp_data_b0", bus.enc_data_o, 64'hD1);
    step();
    check("bp_data_b1", bus.enc_data_o, 64'h1D1);
    rdy_cfg = 1'b0;
    step();
    check("bp_srcv_c3", src_valid_o, 1);
    check("bp_data_c3", bus.enc_data_o, 64'h2D1);
    for (int c = 4; c <= 7; c++) begin
      step();
      check($sformatf("bp_srcv_c%0d", c), src_valid_o, 0);
      check($sformatf("bp_busy_c%0d", c), busy_o, 1);
      check($sformatf("bp_ready_c%0d", c), bus.req_ready_o, 0);
      check($sformatf("bp_data_c%0d", c), bus.enc_data_o, 64'h2D1);
    end
    rdy_cfg = 1'b1;
    step();
    check("bp_resume_ready", bus.req_ready_o, 4'b0010);
    check("bp_resume_data", bus.enc_data_o, 64'h2D1);
    step();
    check("bp_done_busy", busy_o, 0);
    check("bp_done_srcv", src_valid_o, 1);
    check("bp_done_srcid", src_id_o, 1);
    step();
    check("bp_after_srcv", src_valid_o, 0);

    // Single-beat packet, valid-without-sop source, and mid-packet sop.
    clr_srcs();
    pk[3] = 1; nb[3] = 1; base[3] = 64'hFFFF;
    pk[1] = 1; nb[1] = 2; base[1] = 64'h11; nosop[1] = 1'b1;
    do_reset();
    step();
    check("sb_grant", grant_o, 4'b1000);
    check("sb_data", bus.enc_data_o, 64'hFFFF);
    check("sb_flags", {bus.enc_valid_o, bus.enc_sop_o, bus.enc_eop_o}, 3'b111);
    step();
    check("sb_idle", busy_o, 0);
    check("sb_srcv", src_valid_o, 1);
    check("sb_srcid", src_id_o, 3);
    for (int c = 3; c <= 5; c++) begin
      step();
      check($sformatf("nosop_grant_c%0d", c), grant_o, 0);
      check($sformatf("nosop_ready_c%0d", c), bus.req_ready_o, 0);
    end
    pk[1] = 0;
    pk[0] = 1; nb[0] = 3; base[0] = 64'hE0; sopx[0] = 1;
    step();
    check("es_idle_c6", grant_o, 0);
    step();
    check("es_grant_c7", grant_o, 4'b0001);
    check("es_data_c7", bus.enc_data_o, 64'hE0);
    step();
    check("es_sop_fwd", bus.enc_sop_o, 1);
    check("es_data_c8", bus.enc_data_o, 64'h1E0);
    check("es_err_c8", err_sop_o, 0);
    step();
    check("es_err_c9", err_sop_o, 1);
    check("es_busy_c9", busy_o, 1);
    check("es_data_c9", bus.enc_data_o, 64'h2E0);
    step();
    check("es_err_c10", err_sop_o, 0);
    check("es_busy_c10", busy_o, 0);

    // Asynchronous reset between beats 2 and 3 of a source-2 packet.
    clr_srcs();
    pk[0] = 1; nb[0] = 1; base[0] = 64'h60;
    pk[2] = 1; nb[2] = 4; base[2] = 64'h62;
    do_reset();
    step();
    check("ar_grant_c1", grant_o, 4'b0001);
    step();
    check("ar_idle_c2", grant_o, 0);
    step();
    check("ar_grant_c3", grant_o, 4'b0100);
    step();
    step();
    check("ar_data_c5", bus.enc_data_o, 64'h262);
    check("ar_busy_c5", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy_now", busy_o, 0);
    check("ar_grant_now", grant_o, 0);
    check("ar_valid_now", bus.enc_valid_o, 0);
    check("ar_data_now", bus.enc_data_o, 0);
    check("ar_ready_now", bus.req_ready_o, 0);
    check("ar_srcv_now", src_valid_o, 0);
    clr_srcs();
    pk[0] = 1; nb[0] = 1; base[0] = 64'h70;
    pk[1] = 1; nb[1] = 1; base[1] = 64'h71;
    drive_srcs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_restart_grant", grant_o, 4'b0001);
    check("ar_restart_data", bus.enc_data_o, 64'h70);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
